// File: rtl/bus_arbiter_mux.sv
// Purpose: N_CH-way arbitrated data selector feeding one registered output word.
// Latency: 1 cycle from input accept to out_valid; one word per cycle with out_ready high.
// Backpressure: a word held under !out_ready freezes the output and keeps every in_ready low.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   mode                  0 = fixed priority (lowest index wins), 1 = round-robin
//   in_valid/in_data      per-channel request and data (channel k at [k*WIDTH +: WIDTH])
//   in_ready              one-hot accept strobe toward the selected channel
//   out_valid/out_data    registered output word
//   out_ch                index of the channel that supplied out_data
//   out_ready             downstream accept
//   busy                  output word held or any channel requesting
module bus_arbiter_mux #(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 8,
  localparam int CH_W  = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [CH_W-1:0]       out_ch,
  input  logic                  out_ready,
  output logic                  busy
);

  logic [CH_W-1:0] last_gnt;
  logic [CH_W-1:0] sel;
  logic            found;
  int              idx;
  logic            load;

  // Output register can take a new word when empty or draining this cycle.
  // Gating with rst_n keeps in_ready silent for the whole time reset is held.
  assign load = rst_n & (~out_valid | out_ready) & (|in_valid);
  assign busy = out_valid | (|in_valid);

  // One search loop serves both modes: fixed priority starts at channel 0,
  // round-robin starts just after the last grant and wraps.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (mode) begin
        idx = (int'(last_gnt) + 1 + i) % N_CH;
      end else begin
        idx = i;
      end
      if (!found && in_valid[idx]) begin
        sel   = CH_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (load) begin
      in_ready[sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      last_gnt  <= CH_W'(N_CH - 1);
    end else if (load) begin
      // Covers both the empty case and drain-and-refill in the same cycle.
      out_valid <= 1'b1;
      out_data  <= in_data[int'(sel)*WIDTH +: WIDTH];
      out_ch    <= sel;
      last_gnt  <= sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/bus_arbiter_mux.md
Name: bus_arbiter_mux

Overview:
- Parametrised N-channel data-bus selector with a registered output and valid/ready handshakes on every port.
- Generalises the fixed 4:1 bit mux to N_CH channels of WIDTH bits.
- Channel choice comes from a built-in arbiter in fixed-priority or round-robin mode, replacing external select lines.
- Sits between the zone/valve data sources and the shared data bus toward the controller.

Parameters:
- N_CH, 4, number of input channels (2..16).
- WIDTH, 8, data width per channel in bits.
- CH_W, $clog2(N_CH), channel-index width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- in_valid  input  N_CH  per-channel request/data-valid.
- in_data  input  N_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_ready  output  N_CH  one-hot accept strobe; a transfer occurs when in_valid[k] & in_ready[k].
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered selected word.
- out_ch  output  CH_W  index of the channel that supplied out_data.
- out_ready  input  1  downstream accepts when out_valid & out_ready.
- busy  output  1  out_valid | (|in_valid), combinational.

Behaviour:
- Reset values (rst_n low, asynchronous):
  - out_valid = 0, out_data = 0, out_ch = 0.
  - Round-robin pointer last_gnt = N_CH-1, so the first round-robin search starts at channel 0.
  - in_ready = 0 for as long as rst_n is low.
  - Release is synchronous to the next clk edge.
- load condition, combinational: load = (!out_valid | out_ready) & (|in_valid).
- Selection, combinational:
  - mode = 0: sel = lowest k with in_valid[k] = 1.
  - mode = 1: sel = first k with in_valid[k] = 1, searching (last_gnt+1) mod N_CH upward with wrap-around.
- in_ready[sel] = load; all other bits of in_ready are 0. At most one bit is ever high.
- Clock edge when load is true:
  - out_data <= in_data[sel].
  - out_ch <= sel.
  - out_valid <= 1.
  - last_gnt <= sel. last_gnt updates in both modes.
- Clock edge when out_valid & out_ready & !load: out_valid <= 0. out_data and out_ch keep their last values.
- Clock edge when out_valid & !out_ready (stall): out_valid, out_data and out_ch hold stable; in_ready = 0.
- Latency and throughput:
  - Input accept to out_valid is 1 cycle.
  - With out_ready held high, throughput is 1 word per cycle, including back-to-back words from the same channel.
- Simultaneous drain and load in the same cycle: the register is overwritten with the new word and no bubble is inserted.
- mode may change at any cycle and takes effect on the next selection. A held (stalled) word is not affected.
- Round-robin fairness: a continuously requesting channel is granted within N_CH loads.
- Protocol rules:
  - Sources must not make in_valid depend on in_ready.
  - in_valid and in_data must stay stable until accepted.
  - The block tolerates a source that drops in_valid before acceptance; the block then ignores that channel.
- Reset mid-transfer: an in-flight or stalled word is discarded, and no in_ready pulse is produced while rst_n is low.
- No X-propagation: when in_valid = 0, sel = 0, but in_ready stays all-zero.

Test Plan:
- Reset/idle:
  - Stimulus: rst_n = 0, then release with all in_valid = 0.
  - Required: out_valid = 0, out_data = 0, out_ch = 0, in_ready = 0000, busy = 0 for 5 cycles.
- Fixed priority:
  - Stimulus: mode = 0, in_valid = 1010, data ch1 = 8'hA1, ch3 = 8'hC3, out_ready = 1.
  - Required: in_ready = 0010 every cycle; out_data = A1 with out_ch = 1 from the next cycle onward; ch3 is never granted while ch1 requests.
- Round-robin:
  - Stimulus: mode = 1, in_valid = 1111 held, out_ready = 1, data ch k = 8'h10+k.
  - Required: out_ch sequence 0,1,2,3,0,1 and out_data 10,11,12,13,10,11 on consecutive cycles.
- Backpressure:
  - Stimulus: load ch2 = 8'h5A, then out_ready = 0 for 4 cycles while in_valid = 0101.
  - Required: out_data stays 5A, out_ch stays 2, in_ready = 0000 during the stall.
  - Then raise out_ready: out_ch = 0 (RR, after ch2 comes ch3 → wraps to 0) loads on the same edge with no bubble cycle.
- Async reset mid-stall:
  - Stimulus: out_valid = 1, out_ready = 0; pull rst_n low between clock edges.
  - Required: out_valid drops immediately (before the next edge), out_data = 0, in_ready = 0.
  - After release with mode = 1 and in_valid = 1111, the first grant is ch0.
- Mode switch:
  - Stimulus: RR grants ch2, then mode is set to 0 with in_valid = 1100.
  - Required: next grant is ch2 (lowest requester), not ch3.
